irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Downstream consumer of the level interrupt lines produced by the watchdog timer and similar peripherals.
- Registers and optionally edge-detects NUM_IRQ request lines, masks them, and picks the highest-priority (lowest index) eligible source.
- Presents that source to a single CPU-side request/acknowledge/end-of-interrupt handshake.
- One interrupt in service at a time; no nesting.

Parameters:
- NUM_IRQ, 8, number of interrupt source lines (2..32).
- ID_W, $clog2(NUM_IRQ), width of the source ID output.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- irq_in  input  NUM_IRQ  raw source lines, active-high, synchronous to clk (bit 0 = highest priority).
- irq_edge  input  NUM_IRQ  per-source mode, quasi-static: 1 = rising-edge triggered, 0 = level.
- irq_mask  input  NUM_IRQ  per-source enable: 1 = enabled.
- irq_req  output  1  registered request to CPU.
- irq_id  output  ID_W  registered ID of the requested or in-service source; valid while irq_req or in_service.
- irq_ack  input  1  one-cycle pulse: CPU accepts the current request.
- irq_eoi  input  1  one-cycle pulse: CPU finished servicing.
- in_service  output  1  high from ack until eoi.
- pending  output  NUM_IRQ  current pending vector, status only.

Behaviour:
- Reset values: irq_req=0, irq_id=0, in_service=0, pending=0, irq_q (previous-sample register)=0, FSM in IDLE. Reset mid-operation aborts any request or service immediately.
- Sampling: irq_q <= irq_in every cycle; rise = irq_in & ~irq_q.
- Edge source: pending[i] set on rise[i]; cleared on the ack cycle when irq_id==i. If a rise and a clear hit the same bit in the same cycle, set wins.
- Edge source after reset: a source already high when reset releases counts as a rising edge.
- Level source: pending[i] <= irq_in[i] every cycle; ack does not clear it.
- Eligibility: eligible = pending & irq_mask, combinational. Masking does not clear pending; a masked edge event is held until unmasked.
- Selection: sel = lowest-index set bit of eligible.
- Latency: irq_in asserted before edge k -> pending after edge k -> irq_req and irq_id after edge k+1 (two cycles from source to request).
- FSM IDLE: when eligible is nonzero, irq_id <= sel, irq_req <= 1, go to REQ.
- FSM REQ:
  - irq_ack=1 -> irq_req <= 0, in_service <= 1, clear pending[irq_id] if edge mode, go to SERVICE.
  - Else if eligible[irq_id]=0 (level source dropped or source masked) -> withdraw: irq_req <= 0, go to IDLE.
  - irq_id is frozen in REQ; a higher-priority source arriving later does not pre-empt.
- FSM SERVICE: irq_eoi=1 -> in_service <= 0, go to IDLE. New events keep pending but raise no request. The next request (re-arbitrated) appears one cycle after returning to IDLE.
- Ignored inputs: irq_ack outside REQ; irq_eoi outside SERVICE.
- Simultaneous ack and eoi in REQ: ack only. Ack and withdraw condition in the same cycle: ack wins.
- irq_id is held through SERVICE and left unchanged in IDLE until the next request.
- Only one state transition per cycle. No combinational path from irq_in to irq_req.

Test Plan:
- Level source 3 only, mask=0xFF; raise irq_in[3] at cycle 0 -> irq_req=1, irq_id=3 after the 2nd edge; ack -> in_service=1, irq_req=0; eoi with irq_in[3] low -> idle, no further request.
- irq_in[2] and irq_in[5] raised together (level) -> irq_id=2 first; ack, drop [2], eoi -> irq_id=5 requested one cycle after IDLE.
- Edge source 1 (irq_edge[1]=1), 1-cycle pulse -> pending[1] stays 1 until ack, then 0; a second pulse during SERVICE sets pending[1], and a new request with irq_id=1 follows eoi.
- Level source 4 requested, then irq_in[4] dropped before ack -> irq_req falls next cycle, FSM returns to IDLE, a later ack is ignored (in_service stays 0).
- Edge source 6 pulsed while irq_mask[6]=0 -> pending[6]=1, irq_req=0; set mask bit -> irq_req=1, irq_id=6 one cycle later.
- Reset asserted during SERVICE with pending=0x0A -> next cycle all outputs 0; after release with irq_in=0, no request.

Source files
------------

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - interrupt source and CPU handshake bundle for irq_controller
interface irq_controller_if #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
);
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               irq_req;
    logic [ID_W-1:0]    irq_id;
    logic               irq_ack;
    logic               irq_eoi;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending;

    modport master (
        output irq_in, irq_edge, irq_mask, irq_ack, irq_eoi,
        input  irq_req, irq_id, in_service, pending
    );

    modport slave (
        input  irq_in, irq_edge, irq_mask, irq_ack, irq_eoi,
        output irq_req, irq_id, in_service, pending
    );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - priority interrupt controller with single-level request/ack/eoi handshake
module irq_controller #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic           clk,
    input  logic           reset,
    irq_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic               irq_req_q, irq_req_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               in_service_q, in_service_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [ID_W-1:0]    sel;
    logic               ack_take;

    assign rise     = bus.irq_in & ~irq_q;
    assign eligible = pending_q & bus.irq_mask;
    assign ack_take = (state_q == ST_REQ) && bus.irq_ack;

    // Lowest-index eligible source wins; scan downwards so the last hit is the lowest.
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = ID_W'(i);
        end
    end

    // Pending vector: edge sources latch rises until acked (a rise beats a same-cycle clear),
    // level sources simply follow the input.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.irq_edge[i]) begin
                pending_d[i] = rise[i] |
                               (pending_q[i] & ~(ack_take && (irq_id_q == ID_W'(i))));
            end else begin
                pending_d[i] = bus.irq_in[i];
            end
        end
    end

    // Handshake FSM next-state and registered-output values.
    always_comb begin
        state_d      = state_q;
        irq_req_d    = irq_req_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    irq_id_d  = sel;
                    irq_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.irq_ack) begin
                    irq_req_d    = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = ST_SERVICE;
                end else if (!eligible[irq_id_q]) begin
                    irq_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.irq_eoi) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                irq_req_d    = 1'b0;
                in_service_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any request or service in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            irq_req_q    <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_q        <= bus.irq_in;
            pending_q    <= pending_d;
            irq_req_q    <= irq_req_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign bus.irq_req    = irq_req_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench for irq_controller against a behavioural model
module tb_irq_controller;
    localparam int N  = 8;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    irq_controller_if #(.NUM_IRQ(N), .ID_W(IW)) bus ();

    irq_controller #(.NUM_IRQ(N), .ID_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic          req;
        logic [IW-1:0] id;
        logic          svc;
        logic [N-1:0]  pend;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: a request is outstanding, a source is being serviced, or neither.
    bit         m_req, m_svc;
    int         m_id;
    bit [N-1:0] m_pend, m_prev;

    task automatic model_step(input logic [N-1:0] in, input logic [N-1:0] edg,
                              input logic [N-1:0] msk, input bit ack, input bit eoi,
                              input bit rst);
        bit [N-1:0] np;
        bit         acked;
        int         first;
        if (rst) begin
            m_req = 0; m_svc = 0; m_id = 0; m_pend = '0; m_prev = '0;
            return;
        end
        acked = m_req && ack;
        for (int i = 0; i < N; i++) begin
            if (edg[i]) begin
                if (in[i] && !m_prev[i])       np[i] = 1'b1;
                else if (acked && m_id == i)   np[i] = 1'b0;
                else                           np[i] = m_pend[i];
            end else begin
                np[i] = in[i];
            end
        end
        if (m_req) begin
            if (ack) begin
                m_req = 0; m_svc = 1;
            end else if (!(m_pend[m_id] && msk[m_id])) begin
                m_req = 0;
            end
        end else if (m_svc) begin
            if (eoi) m_svc = 0;
        end else begin
            first = -1;
            for (int i = N - 1; i >= 0; i--) if (m_pend[i] && msk[i]) first = i;
            if (first >= 0) begin
                m_id = first; m_req = 1;
            end
        end
        m_pend = np;
        m_prev = in;
    endtask

    // Apply one set of inputs for n cycles; ack/eoi only pulse on the first cycle.
    task automatic drive(input int n, input logic [N-1:0] in, input logic [N-1:0] edg,
                         input logic [N-1:0] msk, input bit ack, input bit eoi,
                         input bit rst);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.irq_in   = in;
            bus.irq_edge = edg;
            bus.irq_mask = msk;
            bus.irq_ack  = (k == 0) ? ack : 1'b0;
            bus.irq_eoi  = (k == 0) ? eoi : 1'b0;
            reset        = rst;
            model_step(in, edg, msk, bus.irq_ack, bus.irq_eoi, rst);
            e.req  = m_req;
            e.id   = IW'(m_id);
            e.svc  = m_svc;
            e.pend = m_pend;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every clock the DUT presents a fresh output set; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total += 4;
                if (bus.irq_req !== e.req) begin
                    bad++;
                    $display("FAIL irq_req t=%0t got=%b exp=%b", $time, bus.irq_req, e.req);
                end
                if (bus.irq_id !== e.id) begin
                    bad++;
                    $display("FAIL irq_id t=%0t got=%0d exp=%0d", $time, bus.irq_id, e.id);
                end
                if (bus.in_service !== e.svc) begin
                    bad++;
                    $display("FAIL in_service t=%0t got=%b exp=%b", $time, bus.in_service, e.svc);
                end
                if (bus.pending !== e.pend) begin
                    bad++;
                    $display("FAIL pending t=%0t got=%h exp=%h", $time, bus.pending, e.pend);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] r_in, r_edge, r_mask;
        bit           ack, eoi, rst;
        bus.irq_in = '0; bus.irq_edge = '0; bus.irq_mask = '0;
        bus.irq_ack = 1'b0; bus.irq_eoi = 1'b0;

        // Reset state
        drive(2, 8'h00, 8'h00, 8'hFF, 0, 0, 1);
        drive(2, 8'h00, 8'h00, 8'hFF, 0, 0, 0);

        // Level source 3: request, ack, eoi with line low
        drive(3, 8'h08, 8'h00, 8'hFF, 0, 0, 0);
        drive(1, 8'h08, 8'h00, 8'hFF, 1, 0, 0);
        drive(2, 8'h00, 8'h00, 8'hFF, 0, 0, 0);
        drive(4, 8'h00, 8'h00, 8'hFF, 0, 1, 0);

        // Sources 2 and 5 together: 2 first, then 5 after eoi
        drive(3, 8'h24, 8'h00, 8'hFF, 0, 0, 0);
        drive(1, 8'h24, 8'h00, 8'hFF, 1, 0, 0);
        drive(2, 8'h20, 8'h00, 8'hFF, 0, 0, 0);
        drive(4, 8'h20, 8'h00, 8'hFF, 0, 1, 0);
        drive(1, 8'h20, 8'h00, 8'hFF, 1, 0, 0);
        drive(1, 8'h00, 8'h00, 8'hFF, 0, 0, 0);
        drive(3, 8'h00, 8'h00, 8'hFF, 0, 1, 0);

        // Edge source 1: pulse held until ack, second pulse during service
        drive(1, 8'h02, 8'h02, 8'hFF, 0, 0, 0);
        drive(3, 8'h00, 8'h02, 8'hFF, 0, 0, 0);
        drive(2, 8'h00, 8'h02, 8'hFF, 1, 0, 0);
        drive(1, 8'h02, 8'h02, 8'hFF, 0, 0, 0);
        drive(2, 8'h00, 8'h02, 8'hFF, 0, 0, 0);
        drive(4, 8'h00, 8'h02, 8'hFF, 0, 1, 0);
        drive(2, 8'h00, 8'h02, 8'hFF, 1, 0, 0);
        drive(2, 8'h00, 8'h02, 8'hFF, 0, 1, 0);

        // Edge source 1: rise on the ack cycle keeps pending set
        drive(1, 8'h02, 8'h02, 8'hFF, 0, 0, 0);
        drive(3, 8'h00, 8'h02, 8'hFF, 0, 0, 0);
        drive(1, 8'h02, 8'h02, 8'hFF, 1, 0, 0);
        drive(3, 8'h00, 8'h02, 8'hFF, 0, 0, 0);
        drive(3, 8'h00, 8'h02, 8'hFF, 0, 1, 0);
        drive(2, 8'h00, 8'h02, 8'hFF, 1, 0, 0);
        drive(2, 8'h00, 8'h02, 8'hFF, 0, 1, 0);

        // Level source 4 withdrawn before ack; late ack ignored; stray eoi ignored
        drive(3, 8'h10, 8'h00, 8'hFF, 0, 0, 0);
        drive(2, 8'h00, 8'h00, 8'hFF, 0, 0, 0);
        drive(3, 8'h00, 8'h00, 8'hFF, 1, 0, 0);
        drive(2, 8'h00, 8'h00, 8'hFF, 0, 1, 0);

        // Masked edge source 6 held, then unmasked
        drive(1, 8'h40, 8'h40, 8'hBF, 0, 0, 0);
        drive(3, 8'h00, 8'h40, 8'hBF, 0, 0, 0);
        drive(3, 8'h00, 8'h40, 8'hFF, 0, 0, 0);
        drive(2, 8'h00, 8'h40, 8'hFF, 1, 0, 0);
        drive(2, 8'h00, 8'h40, 8'hFF, 0, 1, 0);

        // Reset during service with pending 0x0A, and edge source already high at release
        drive(3, 8'h0A, 8'h00, 8'hFF, 0, 0, 0);
        drive(3, 8'h0A, 8'h00, 8'hFF, 1, 0, 0);
        drive(1, 8'h00, 8'h00, 8'hFF, 0, 0, 1);
        drive(4, 8'h00, 8'h00, 8'hFF, 0, 0, 0);
        drive(1, 8'h01, 8'h01, 8'hFF, 0, 0, 1);
        drive(4, 8'h01, 8'h01, 8'hFF, 0, 0, 0);
        drive(2, 8'h01, 8'h01, 8'hFF, 1, 0, 0);
        drive(2, 8'h00, 8'h01, 8'hFF, 0, 1, 0);

        // Randomized traffic
        r_in = '0; r_edge = '0; r_mask = 8'hFF;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                r_edge = 8'($urandom);
                r_mask = 8'($urandom);
            end else if ($urandom_range(0, 40) == 0) begin
                r_mask[$urandom_range(0, N - 1)] ^= 1'b1;
            end
            for (int b = 0; b < N; b++) if ($urandom_range(0, 11) == 0) r_in[b] = ~r_in[b];
            ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
            eoi = m_svc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 599) == 0);
            drive(1, r_in, r_edge, r_mask, ack, eoi, rst);
        end

        @(posedge clk);
        #3;
        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
